pulse_count_glyph_sequencer: RTL and testbench
==============================================

// Module: pulse_count_glyph_sequencer
// PURPOSE
//  Converts a latched NUM_DIGITS-digit BCD pulse count into a stream of glyph-ROM base addresses, one per digit, MSB first.
//  Each address carries a valid/ready handshake for the TFT character blitter.
//  Sits between the pulse counter's BCD outputs and the TFT43 text renderer.
//  Adds a frame snapshot, optional leading-zero blanking and backpressure over the plain per-digit glyph mux.
// PARAMETERS
//  NUM_DIGITS    8     number of BCD digits in bcd_in (>=1)
//  ADDR_W        12    glyph_addr width; must hold GLYPH_BASE+11*GLYPH_STRIDE
//  GLYPH_BASE    1024  ROM address of glyph code 0 ('0')
//  GLYPH_STRIDE  36    ROM words per glyph
//  POS_W         3     width of glyph_pos; must hold NUM_DIGITS-1
// PORTS
//  clk          in   1               system clock, all logic rising-edge
//  rst_n        in   1               asynchronous active-low reset
//  start        in   1               request a frame; sampled only in IDLE
//  lz_blank     in   1               1 = blank leading zeros; sampled with start
//  bcd_in       in   4*NUM_DIGITS    BCD count; [3:0] = digit 0 = LSB
//  busy         out  1               high from accepted start until done
//  glyph_valid  out  1               glyph_addr/glyph_pos/glyph_last valid
//  glyph_ready  in   1               consumer accepts current glyph
//  glyph_addr   out  ADDR_W          GLYPH_BASE + code*GLYPH_STRIDE
//  glyph_pos    out  POS_W           digit index of the current glyph (NUM_DIGITS-1 first)
//  glyph_last   out  1               current glyph is digit 0
//  done         out  1               one-cycle pulse after the last handshake
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; snapshot register 0. Reset is asynchronous and may abort a frame at any point; no done is issued.
//  FSM states and transitions:
//   IDLE -> LOAD on the edge where start=1. At that edge, bcd_in and lz_blank are latched into shadow registers and busy is set to 1.
//   LOAD -> EMIT on the next edge. Registered outputs become active: glyph_valid=1, glyph_pos=NUM_DIGITS-1.
//    Latency: glyph_valid is high 2 edges after start is sampled.
//   EMIT, on an edge with glyph_valid & glyph_ready:
//    - if glyph_last=0: load the next lower digit; glyph_valid stays 1 (no bubble, 1 glyph/clk at full throughput).
//    - if glyph_last=1: glyph_valid=0, busy=0, done=1 for one cycle, state -> IDLE.
//   EMIT with glyph_ready=0: glyph_addr, glyph_pos and glyph_last are held stable and glyph_valid stays 1.
//  start while busy: ignored (no queueing). start in the done cycle: accepted, since the FSM is already in IDLE.
//  bcd_in changes after the snapshot have no effect on the frame in progress.
//  Code mapping per digit d:
//   - d=0..9 -> code d
//   - d=10 -> code 10 (':')
//   - d=11..15 -> code 0
//   - blanked -> code 11 (space glyph)
//  Blanking: with lz_blank latched 1, a digit is blanked if it and every higher digit equal 0. Digit 0 is never blanked.
//  Address arithmetic: 32-bit integer, truncated to ADDR_W. No multiplier is needed; a constant table or shift-add is acceptable.
//  glyph_last = (glyph_pos == 0). For NUM_DIGITS=1 the first glyph is also the last.
// TESTING
//  1. bcd_in=32'h00012345, lz_blank=0, ready=1 -> addr 1024,1024,1024,1060,1096,1132,1168,1204; pos 7..0; done 1 cycle after pos 0.
//  2. Same count, lz_blank=1 -> addr 1420,1420,1420,1060,1096,1132,1168,1204.
//  3. bcd_in=0, lz_blank=1 -> seven 1420 then 1024 with glyph_last=1.
//  4. Digit values 4'hA and 4'hF -> 1384 and 1024 respectively.
//  5. Backpressure: ready=0 for 5 cycles on pos 3 -> addr/pos stable, valid held. Change bcd_in mid-frame -> output unchanged.
//  6. start pulsed while busy -> ignored. rst_n low at pos 4 -> all outputs 0 at once, no done. Next start runs a full frame.

Source files
------------

// File: rtl/pulse_count_glyph_sequencer.sv
// Streams a latched BCD pulse count to the TFT blitter as glyph-ROM base addresses.
// Digits go out MSB first over a valid/ready handshake, with optional leading-zero blanking.
module pulse_count_glyph_sequencer #(
    parameter int NUM_DIGITS   = 8,
    parameter int ADDR_W       = 12,
    parameter int GLYPH_BASE   = 1024,
    parameter int GLYPH_STRIDE = 36,
    parameter int POS_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    lz_blank,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    glyph_valid,
    input  logic                    glyph_ready,
    output logic [ADDR_W-1:0]       glyph_addr,
    output logic [POS_W-1:0]        glyph_pos,
    output logic                    glyph_last,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                  state_r;
    logic [4*NUM_DIGITS-1:0] snap_r;
    logic                    lz_r;
    logic                    zrun_r;

    logic [POS_W-1:0]  sel_pos_s;
    logic [3:0]        sel_digit_s;
    logic              zrun_in_s;
    logic              zrun_next_s;
    logic [ADDR_W-1:0] sel_addr_s;

    function automatic logic [3:0] glyph_code(input logic [3:0] digit, input logic blank);
        logic [3:0] code;
        if (blank) begin
            code = 4'd11;
        end else begin
            case (digit)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9: code = digit;
                4'd10:                        code = 4'd10;
                default:                      code = 4'd0;
            endcase
        end
        return code;
    endfunction

    function automatic logic [ADDR_W-1:0] glyph_address(input logic [3:0] code);
        int unsigned addr;
        addr = 32'(GLYPH_BASE) + 32'(code) * 32'(GLYPH_STRIDE);
        return ADDR_W'(addr);
    endfunction

    // Select the digit to present next; zrun tracks "every digit so far was zero" under blanking.
    always_comb begin
        sel_pos_s = glyph_pos - POS_W'(1);
        zrun_in_s = zrun_r;
        if (state_r == LOAD) begin
            sel_pos_s = POS_W'(NUM_DIGITS - 1);
            zrun_in_s = lz_r;
        end else begin
            zrun_in_s = zrun_r;
        end
        sel_digit_s = snap_r[int'(sel_pos_s) * 4 +: 4];
        zrun_next_s = zrun_in_s & (sel_digit_s == 4'd0);
        sel_addr_s  = glyph_address(glyph_code(sel_digit_s,
                                               zrun_next_s & (sel_pos_s != {POS_W{1'b0}})));
    end

    // Frame sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            snap_r      <= {(4*NUM_DIGITS){1'b0}};
            lz_r        <= 1'b0;
            zrun_r      <= 1'b0;
            busy        <= 1'b0;
            glyph_valid <= 1'b0;
            glyph_addr  <= {ADDR_W{1'b0}};
            glyph_pos   <= {POS_W{1'b0}};
            glyph_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        snap_r  <= bcd_in;
                        lz_r    <= lz_blank;
                        busy    <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    glyph_valid <= 1'b1;
                    glyph_pos   <= sel_pos_s;
                    glyph_addr  <= sel_addr_s;
                    glyph_last  <= (sel_pos_s == {POS_W{1'b0}});
                    zrun_r      <= zrun_next_s;
                    state_r     <= EMIT;
                end
                EMIT: begin
                    if (glyph_ready) begin
                        if (glyph_last) begin
                            glyph_valid <= 1'b0;
                            glyph_addr  <= {ADDR_W{1'b0}};
                            glyph_pos   <= {POS_W{1'b0}};
                            glyph_last  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state_r     <= IDLE;
                        end else begin
                            glyph_pos  <= sel_pos_s;
                            glyph_addr <= sel_addr_s;
                            glyph_last <= (sel_pos_s == {POS_W{1'b0}});
                            zrun_r     <= zrun_next_s;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_count_glyph_sequencer.sv
// Randomised and directed bench for pulse_count_glyph_sequencer, checked every cycle
// against a frame-level reference model built from the digit/glyph rules.
module tb_pulse_count_glyph_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         lz_blank = 1'b0;
    logic [31:0]  bcd_in = 32'd0;
    logic         busy;
    logic         glyph_valid;
    logic         glyph_ready = 1'b0;
    logic [11:0]  glyph_addr;
    logic [2:0]   glyph_pos;
    logic         glyph_last;
    logic         done;

    int checks = 0;
    int failures = 0;

    pulse_count_glyph_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lz_blank(lz_blank), .bcd_in(bcd_in),
        .busy(busy), .glyph_valid(glyph_valid), .glyph_ready(glyph_ready),
        .glyph_addr(glyph_addr), .glyph_pos(glyph_pos), .glyph_last(glyph_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = list of eight addresses, walked one per accepted handshake.
    int m_phase = 0;
    int m_k = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_addr[N];

    function automatic void build_frame(input logic [31:0] bcd, input logic lz);
        bit all_zero;
        int d;
        int code;
        int pos;
        all_zero = 1'b1;
        for (int k = 0; k < N; k++) begin
            pos = N - 1 - k;
            d = int'(bcd[pos*4 +: 4]);
            all_zero = all_zero && (d == 0);
            if (lz && all_zero && pos != 0) code = 11;
            else if (d <= 10) code = d;
            else code = 0;
            m_addr[k] = 1024 + code * 36;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    build_frame(bcd_in, lz_blank);
                    m_busy = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_k = 0;
            end else if (glyph_ready) begin
                if (m_k == N - 1) begin
                    m_phase = 0; m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_k++;
                end
            end
        end
    end

    int log_addr[$];
    int log_pos[$];

    // Compare DUT to model away from the active edge; log accepted glyphs.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_valid", 32'(glyph_valid), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_addr", 32'(glyph_addr), 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("valid", 32'(glyph_valid), 32'(m_phase == 2));
            chk("done", 32'(done), 32'(m_done));
            if (m_phase == 2) begin
                chk("addr", 32'(glyph_addr), 32'(m_addr[m_k]));
                chk("pos", 32'(glyph_pos), 32'(N - 1 - m_k));
                chk("last", 32'(glyph_last), 32'(m_k == N - 1));
            end
            if (glyph_valid && glyph_ready) begin
                log_addr.push_back(int'(glyph_addr));
                log_pos.push_back(int'(glyph_pos));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic kick(input logic [31:0] bcd, input logic lz);
        bcd_in = bcd; lz_blank = lz; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_frame(input bit rand_ready);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            glyph_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_log(input string name, input int e0, input int e1, input int e2, input int e3,
                             input int e4, input int e5, input int e6, input int e7);
        int exp[8];
        exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
        chk({name, "_len"}, 32'(log_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            chk(name, 32'(log_addr[i]), 32'(exp[i]));
            chk({name, "_pos"}, 32'(log_pos[i]), 32'(7 - i));
        end
        log_addr.delete();
        log_pos.delete();
    endtask

    task automatic wait_pos(input logic [2:0] p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (glyph_valid && glyph_pos == p) seen = 1'b1;
            else step();
        end
        chk("wait_pos", 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset state
        step();
        chk("reset_valid", 32'(glyph_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: plain frame at full throughput
        glyph_ready = 1'b1;
        kick(32'h0001_2345, 1'b0);
        chk("latency_load", 32'(glyph_valid), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        step();
        chk("latency_valid", 32'(glyph_valid), 32'd1);
        finish_frame(1'b0);
        check_log("t1", 1024, 1024, 1024, 1060, 1096, 1132, 1168, 1204);

        // 2: leading-zero blanking
        kick(32'h0001_2345, 1'b1);
        finish_frame(1'b0);
        check_log("t2", 1420, 1420, 1420, 1060, 1096, 1132, 1168, 1204);

        // 3: zero count keeps digit 0
        kick(32'h0000_0000, 1'b1);
        finish_frame(1'b0);
        check_log("t3", 1420, 1420, 1420, 1420, 1420, 1420, 1420, 1024);

        // 4: colon and invalid BCD
        kick(32'h0000_00AF, 1'b0);
        finish_frame(1'b0);
        check_log("t4", 1024, 1024, 1024, 1024, 1024, 1024, 1384, 1024);

        // 5: backpressure on pos 3, bcd_in changed mid-frame
        kick(32'h8765_4321, 1'b0);
        wait_pos(3'd3);
        glyph_ready = 1'b0;
        bcd_in = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_addr", 32'(glyph_addr), 32'd1168);
            chk("stall_pos", 32'(glyph_pos), 32'd3);
        end
        finish_frame(1'b0);
        check_log("t5", 1312, 1276, 1240, 1204, 1168, 1132, 1096, 1060);

        // 6: start while busy ignored, then async reset mid-frame
        kick(32'h1111_1111, 1'b0);
        start = 1'b1; bcd_in = 32'h9999_9999;
        step(); step(); step();
        start = 1'b0;
        finish_frame(1'b0);
        check_log("t6", 1060, 1060, 1060, 1060, 1060, 1060, 1060, 1060);
        step(); step();
        chk("idle_after_ignored", 32'(busy), 32'd0);

        kick(32'h2222_2222, 1'b0);
        wait_pos(3'd4);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(glyph_valid), 32'd0);
        chk("async_addr", 32'(glyph_addr), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        step(); step();
        rst_n = 1'b1;
        log_addr.delete(); log_pos.delete();
        step();
        kick(32'h0000_0007, 1'b1);
        finish_frame(1'b0);
        check_log("t6b", 1420, 1420, 1420, 1420, 1420, 1420, 1420, 1276);

        // Randomised frames, random backpressure, back-to-back starts in the done cycle
        for (int f = 0; f < 40; f++) begin
            kick($urandom, 1'($urandom_range(0, 1)));
            finish_frame(1'b1);
        end
        log_addr.delete(); log_pos.delete();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
